// File: rtl/vx_gather_merge_unit_pkg.sv
// vx_gather_merge_unit_pkg: shared sizes, accumulator record and FSM states for the gather-merge unit.
package vx_gather_merge_unit_pkg;

    localparam int NUM_THREADS   = 8;
    localparam int ISSUE_WIDTH   = 2;
    localparam int NUM_WARPS     = 4;
    localparam int ISSUE_ISW_W   = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
    localparam int NW_W          = $clog2(NUM_WARPS);
    localparam int UUID_W        = 16;
    localparam int PC_W          = 32;
    localparam int RD_W          = 5;
    localparam int XLEN          = 32;
    localparam int PERF_CTR_BITS = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, FULL} gather_state_t;

    typedef struct packed {
        logic [UUID_W-1:0]                uuid;
        logic [NW_W-1:0]                  wid;
        logic [NUM_THREADS-1:0]           tmask;
        logic [PC_W-1:0]                  pc;
        logic                             wb;
        logic [RD_W-1:0]                  rd;
        logic [NUM_THREADS-1:0][XLEN-1:0] data;
        logic                             tensor;
    } gather_accum_t;

    // Packets per warp is NUM_THREADS / lanes; zero bits means every packet is a whole warp.
    function automatic int pid_bits(int lanes);
        return $clog2(NUM_THREADS / lanes);
    endfunction

endpackage

// File: rtl/vx_gather_merge_unit_accum.sv
// vx_gather_merge_unit_accum: per-slot IDLE/ACCUM/FULL FSM that merges partial-warp packets
// into one full-warp commit record.
module vx_gather_merge_unit_accum
    import vx_gather_merge_unit_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int PID_W     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pkt_valid,
    output logic                             pkt_ready,
    input  logic [UUID_W-1:0]                pkt_uuid,
    input  logic [NW_W-1:0]                  pkt_wid,
    input  logic [NUM_LANES-1:0]             pkt_tmask,
    input  logic [PC_W-1:0]                  pkt_pc,
    input  logic                             pkt_wb,
    input  logic [RD_W-1:0]                  pkt_rd,
    input  logic [NUM_LANES-1:0][XLEN-1:0]   pkt_data,
    input  logic                             pkt_tensor,
    input  logic [PID_W-1:0]                 pkt_pid,
    input  logic                             pkt_sop,
    input  logic                             pkt_eop,
    output logic                             merged_valid,
    input  logic                             merged_ready,
    output gather_accum_t                    merged
);

    localparam int PID_BITS = pid_bits(NUM_LANES);

    gather_state_t state, state_n;
    gather_accum_t acc, acc_n;
    logic is_sop, is_eop, take, restart;

    always_comb begin
        is_sop    = (PID_BITS == 0) || pkt_sop;
        is_eop    = (PID_BITS == 0) || pkt_eop;
        pkt_ready = (state == FULL) ? merged_ready : 1'b1;
        take      = pkt_valid && pkt_ready;
        // A FULL-state acceptance implies the pending commit fires, so it restarts like IDLE.
        restart   = take && ((state != ACCUM) || is_sop);
        state_n   = take ? (is_eop ? FULL : ACCUM)
                  : ((state == FULL) && merged_ready) ? IDLE : state;
        acc_n     = acc;
        if (restart) begin
            acc_n.uuid   = pkt_uuid;
            acc_n.wid    = pkt_wid;
            acc_n.pc     = pkt_pc;
            acc_n.wb     = pkt_wb;
            acc_n.rd     = pkt_rd;
            acc_n.tensor = pkt_tensor;
            acc_n.tmask  = '0;
        end
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (take && ((PID_BITS == 0) || (t / NUM_LANES == int'(pkt_pid)))) begin
                acc_n.tmask[t] = pkt_tmask[t % NUM_LANES];
                acc_n.data[t]  = pkt_data[t % NUM_LANES];
            end
        end
    end

    always_ff @(posedge clk) begin
        acc <= acc_n;
        if (reset) begin
            state     <= IDLE;
            acc.tmask <= '0;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && take) begin
            assert (state == ACCUM ? !is_sop : is_sop);
            assert (state != ACCUM || is_sop || pkt_wid == acc.wid);
        end
    end

    assign merged_valid = (state == FULL);
    assign merged       = acc;

endmodule

// File: rtl/vx_gather_merge_unit.sv
// vx_gather_merge_unit: routes partial-warp commits to issue slots and merges them into full-warp
// commits; optional per-slot stall counters when GATHER_PERF_EN is defined.
module vx_gather_merge_unit
    import vx_gather_merge_unit_pkg::*;
#(
    parameter int  BLOCK_SIZE = 1,
    parameter int  NUM_LANES  = 1,
    parameter int  OUT_REG    = 0,
    localparam int PID_BITS   = pid_bits(NUM_LANES),
    localparam int PID_W      = (PID_BITS > 0) ? PID_BITS : 1
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [BLOCK_SIZE-1:0]                            commit_in_valid,
    output logic [BLOCK_SIZE-1:0]                            commit_in_ready,
    input  logic [BLOCK_SIZE-1:0][UUID_W-1:0]                commit_in_uuid,
    input  logic [BLOCK_SIZE-1:0][NW_W-1:0]                  commit_in_wid,
    input  logic [BLOCK_SIZE-1:0][NUM_LANES-1:0]             commit_in_tmask,
    input  logic [BLOCK_SIZE-1:0][PC_W-1:0]                  commit_in_pc,
    input  logic [BLOCK_SIZE-1:0]                            commit_in_wb,
    input  logic [BLOCK_SIZE-1:0][RD_W-1:0]                  commit_in_rd,
    input  logic [BLOCK_SIZE-1:0][NUM_LANES-1:0][XLEN-1:0]   commit_in_data,
    input  logic [BLOCK_SIZE-1:0]                            commit_in_tensor,
    input  logic [BLOCK_SIZE-1:0][PID_W-1:0]                 commit_in_pid,
    input  logic [BLOCK_SIZE-1:0]                            commit_in_sop,
    input  logic [BLOCK_SIZE-1:0]                            commit_in_eop,
`ifdef GATHER_PERF_EN
    output logic [ISSUE_WIDTH-1:0][PERF_CTR_BITS-1:0]        perf_stalls,
`endif
    output logic [ISSUE_WIDTH-1:0]                           commit_out_valid,
    input  logic [ISSUE_WIDTH-1:0]                           commit_out_ready,
    output gather_accum_t [ISSUE_WIDTH-1:0]                  commit_out_data,
    output logic [ISSUE_WIDTH-1:0]                           commit_out_pid,
    output logic [ISSUE_WIDTH-1:0]                           commit_out_sop,
    output logic [ISSUE_WIDTH-1:0]                           commit_out_eop
);

    localparam int BLOCK_SIZE_W = $clog2(BLOCK_SIZE);

    logic [ISSUE_WIDTH-1:0] sel, slot_valid, slot_ready, acc_valid, acc_ready;
    gather_accum_t [ISSUE_WIDTH-1:0] acc_data;

    // Slot s takes input s % BLOCK_SIZE; with fewer inputs than slots the warp id picks the upper slot bits.
    always_comb begin
        commit_in_ready = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            sel[s] = (BLOCK_SIZE == ISSUE_WIDTH)
                  || (((int'(commit_in_wid[s % BLOCK_SIZE]) >> BLOCK_SIZE_W) % (ISSUE_WIDTH / BLOCK_SIZE)) == s / BLOCK_SIZE);
            slot_valid[s] = commit_in_valid[s % BLOCK_SIZE] && sel[s];
            if (sel[s])
                commit_in_ready[s % BLOCK_SIZE] = slot_ready[s];
        end
    end

    assign commit_out_pid = '0;
    assign commit_out_sop = '1;
    assign commit_out_eop = '1;

    for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_slot
        localparam int SRC = s % BLOCK_SIZE;

        vx_gather_merge_unit_accum #(
            .NUM_LANES (NUM_LANES),
            .PID_W     (PID_W)
        ) u_accum (
            .clk          (clk),
            .reset        (reset),
            .pkt_valid    (slot_valid[s]),
            .pkt_ready    (slot_ready[s]),
            .pkt_uuid     (commit_in_uuid[SRC]),
            .pkt_wid      (commit_in_wid[SRC]),
            .pkt_tmask    (commit_in_tmask[SRC]),
            .pkt_pc       (commit_in_pc[SRC]),
            .pkt_wb       (commit_in_wb[SRC]),
            .pkt_rd       (commit_in_rd[SRC]),
            .pkt_data     (commit_in_data[SRC]),
            .pkt_tensor   (commit_in_tensor[SRC]),
            .pkt_pid      (commit_in_pid[SRC]),
            .pkt_sop      (commit_in_sop[SRC]),
            .pkt_eop      (commit_in_eop[SRC]),
            .merged_valid (acc_valid[s]),
            .merged_ready (acc_ready[s]),
            .merged       (acc_data[s])
        );

        if (OUT_REG == 0) begin : g_bypass
            assign commit_out_valid[s] = acc_valid[s];
            assign commit_out_data[s]  = acc_data[s];
            assign acc_ready[s]        = commit_out_ready[s];
        end else begin : g_pipe
            logic          eb_valid;
            gather_accum_t eb_data;
            assign acc_ready[s] = !eb_valid || commit_out_ready[s];
            always_ff @(posedge clk) begin
                if (reset)
                    eb_valid <= 1'b0;
                else if (acc_ready[s])
                    eb_valid <= acc_valid[s];
                if (acc_ready[s] && acc_valid[s])
                    eb_data <= acc_data[s];
            end
            assign commit_out_valid[s] = eb_valid;
            assign commit_out_data[s]  = eb_data;
        end

`ifdef GATHER_PERF_EN
        always_ff @(posedge clk) begin
            if (reset)
                perf_stalls[s] <= '0;
            else if (acc_valid[s] && !acc_ready[s])
                perf_stalls[s] <= perf_stalls[s] + PERF_CTR_BITS'(1);
        end
`endif
    end

endmodule
